audio_frame_sequencer: RTL and testbench

AUDIO_FRAME_SEQUENCER -- requirements
Module: audio_frame_sequencer

---
 rtl/audio_seq_pkg.sv | 23 ++
 rtl/audio_seq_timer.sv | 33 +++
 rtl/audio_frame_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_audio_frame_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_seq_pkg.sv
// Shared definitions for the audio frame sequencer: sequencer state
// encoding, default widths/timings and a counter-width helper.
package audio_seq_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE     = 2'd0,
    SEQ_WARMUP   = 2'd1,
    SEQ_WAIT_SMP = 2'd2,
    SEQ_RUN      = 2'd3
  } seq_state_e;

  localparam int unsigned DEF_DATA_W       = 24;
  localparam int unsigned DEF_PRE_SHIFT    = 3;
  localparam int unsigned DEF_WARMUP_CYC   = 64;
  localparam int unsigned DEF_FILT_TIMEOUT = 255;
  localparam int unsigned CODEC_WORD_W     = 32;

  // Bits needed to hold the values 0 .. limit-1 (never less than one bit).
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit < 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/audio_seq_timer.sv
// Cycle timer used for codec warm-up and filter watchdog.
// load clears the count; while count is high the timer advances once per
// cycle and raises expire on the LIMIT-th counted cycle.
module audio_seq_timer
  import audio_seq_pkg::*;
#(
  parameter int unsigned LIMIT = DEF_WARMUP_CYC
) (
  input  logic lmmi_clk_i,
  input  logic reset_n_i,
  input  logic load,
  input  logic count,
  output logic expire
);

  localparam int unsigned CW = cnt_width(LIMIT);

  logic [CW-1:0] cnt_reg;

  assign expire = count && (cnt_reg == CW'(LIMIT - 1));

  // Cycle counter: cleared on load, parks at its terminal value on expire.
  always_ff @(posedge lmmi_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= '0;
    end else if (count && !expire) begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

endmodule

// File: rtl/audio_frame_sequencer.sv
// Audio frame sequencer: warms up the codecs, forwards each RX sample
// (shifted) to an external filter, returns the filter result to TX and
// flags dropped samples and filter timeouts.
// Optional build macro AUDIO_SEQ_OVF_CNT_EN adds a saturating 16-bit
// overrun+timeout counter on port ovf_cnt_o.
module audio_frame_sequencer
  import audio_seq_pkg::*;
#(
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned PRE_SHIFT    = DEF_PRE_SHIFT,
  parameter int unsigned WARMUP_CYC   = DEF_WARMUP_CYC,
  parameter int unsigned FILT_TIMEOUT = DEF_FILT_TIMEOUT
) (
  input  logic                     lmmi_clk_i,
  input  logic                     reset_n_i,
  input  logic                     enable_i,
  output logic                     conf_en_o,
  input  logic                     adc_valid_i,
  input  logic [31:0]              adc_data_i,
  output logic signed [DATA_W-1:0] filt_in_o,
  output logic                     filt_start_o,
  input  logic                     filt_done_i,
  input  logic signed [DATA_W-1:0] filt_out_i,
  output logic [31:0]              dac_data_o,
  output logic                     ch_o,
  output logic                     overrun_o,
`ifdef AUDIO_SEQ_OVF_CNT_EN
  output logic [15:0]              ovf_cnt_o,
`endif
  output logic                     timeout_o
);

  localparam logic [1:0] ST_IDLE     = SEQ_IDLE;
  localparam logic [1:0] ST_WARMUP   = SEQ_WARMUP;
  localparam logic [1:0] ST_WAIT_SMP = SEQ_WAIT_SMP;
  localparam logic [1:0] ST_RUN      = SEQ_RUN;

  localparam int TMR_WARM = 0;
  localparam int TMR_FILT = 1;

  logic [1:0]               state_reg, state_next;
  logic                     conf_en_reg, conf_en_next;
  logic signed [DATA_W-1:0] filt_in_reg, filt_in_next;
  logic                     filt_start_reg, filt_start_next;
  logic [31:0]              dac_reg, dac_next;
  logic                     ch_reg, ch_next;
  logic                     overrun_reg, overrun_next;
  logic                     timeout_reg, timeout_next;

  logic [1:0] tmr_load;
  logic [1:0] tmr_count;
  logic [1:0] tmr_expire;

  logic signed [DATA_W-1:0] smp_raw;
  logic signed [DATA_W-1:0] smp_shifted;
  logic [31:0]              dac_result;
  logic                     unused_adc_hi;

  // Only the low DATA_W bits of the codec word carry the sample.
  assign smp_raw       = adc_data_i[DATA_W-1:0];
  assign smp_shifted   = smp_raw >>> PRE_SHIFT;
  assign dac_result    = 32'(filt_out_i);
  assign unused_adc_hi = &{1'b0, adc_data_i};

  // One timer per timed state: index 0 times warm-up, index 1 the filter.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_tmr
      localparam logic [1:0]  TMR_ST    = (gi == TMR_WARM) ? ST_WARMUP : ST_RUN;
      localparam int unsigned TMR_LIMIT = (gi == TMR_WARM) ? WARMUP_CYC : FILT_TIMEOUT;

      assign tmr_count[gi] = (state_reg == TMR_ST);
      assign tmr_load[gi]  = ~tmr_count[gi];

      audio_seq_timer #(
        .LIMIT (TMR_LIMIT)
      ) u_timer (
        .lmmi_clk_i (lmmi_clk_i),
        .reset_n_i  (reset_n_i),
        .load       (tmr_load[gi]),
        .count      (tmr_count[gi]),
        .expire     (tmr_expire[gi])
      );
    end
  endgenerate

  // Next-state and next-output logic; enable_i low overrides everything.
  always_comb begin
    state_next      = state_reg;
    conf_en_next    = conf_en_reg;
    filt_in_next    = filt_in_reg;
    filt_start_next = 1'b0;
    dac_next        = dac_reg;
    ch_next         = ch_reg;
    overrun_next    = 1'b0;
    timeout_next    = 1'b0;
    if (!enable_i) begin
      state_next   = ST_IDLE;
      conf_en_next = 1'b0;
      dac_next     = '0;
      ch_next      = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: state_next = ST_WARMUP;
        ST_WARMUP: begin
          if (tmr_expire[TMR_WARM]) begin
            state_next   = ST_WAIT_SMP;
            conf_en_next = 1'b1;
          end
        end
        ST_WAIT_SMP: begin
          if (adc_valid_i) begin
            filt_in_next    = smp_shifted;
            filt_start_next = 1'b1;
            ch_next         = ~ch_reg;
            state_next      = ST_RUN;
          end
        end
        ST_RUN: begin
          // A result arriving on the watchdog's last cycle still wins.
          if (filt_done_i) begin
            dac_next   = dac_result;
            state_next = ST_WAIT_SMP;
          end else if (tmr_expire[TMR_FILT]) begin
            dac_next     = '0;
            timeout_next = 1'b1;
            state_next   = ST_WAIT_SMP;
          end
          // Any sample arriving while busy is dropped; ch still toggles so
          // left/right parity follows the codec stream.
          if (adc_valid_i) begin
            overrun_next = 1'b1;
            ch_next      = ~ch_reg;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge lmmi_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg      <= ST_IDLE;
      conf_en_reg    <= 1'b0;
      filt_in_reg    <= '0;
      filt_start_reg <= 1'b0;
      dac_reg        <= '0;
      ch_reg         <= 1'b0;
      overrun_reg    <= 1'b0;
      timeout_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      conf_en_reg    <= conf_en_next;
      filt_in_reg    <= filt_in_next;
      filt_start_reg <= filt_start_next;
      dac_reg        <= dac_next;
      ch_reg         <= ch_next;
      overrun_reg    <= overrun_next;
      timeout_reg    <= timeout_next;
    end
  end

  assign conf_en_o    = conf_en_reg;
  assign filt_in_o    = filt_in_reg;
  assign filt_start_o = filt_start_reg;
  assign dac_data_o   = dac_reg;
  assign ch_o         = ch_reg;
  assign overrun_o    = overrun_reg;
  assign timeout_o    = timeout_reg;

`ifdef AUDIO_SEQ_OVF_CNT_EN
  logic [15:0] ovf_reg, ovf_next;
  logic [16:0] ovf_sum;

  // Overrun and timeout can land on the same cycle, so add both.
  always_comb begin
    ovf_sum = {1'b0, ovf_reg} + {16'd0, overrun_next} + {16'd0, timeout_next};
    if (!enable_i) begin
      ovf_next = '0;
    end else if (ovf_sum[16]) begin
      ovf_next = 16'hFFFF;
    end else begin
      ovf_next = ovf_sum[15:0];
    end
  end

  // Saturating event counter register.
  always_ff @(posedge lmmi_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ovf_reg <= '0;
    end else begin
      ovf_reg <= ovf_next;
    end
  end

  assign ovf_cnt_o = ovf_reg;
`endif

endmodule

// File: tb/tb_audio_frame_sequencer.sv
// Bench for audio_frame_sequencer: directed scenarios followed by random
// traffic, checked every cycle against a behavioural model.
module tb_audio_frame_sequencer;

  localparam int DW    = 24;
  localparam int SHIFT = 3;
  localparam int WARM  = 64;
  localparam int TOUT  = 255;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          adc_valid = 1'b0;
  logic [31:0]   adc_data = '0;
  logic          filt_done = 1'b0;
  logic [DW-1:0] filt_out = '0;

  logic          conf_en_o;
  logic [DW-1:0] filt_in_o;
  logic          filt_start_o;
  logic [31:0]   dac_data_o;
  logic          ch_o;
  logic          overrun_o;
  logic          timeout_o;
`ifdef AUDIO_SEQ_OVF_CNT_EN
  logic [15:0]   ovf_cnt_o;
`endif

  audio_frame_sequencer #(
    .DATA_W       (DW),
    .PRE_SHIFT    (SHIFT),
    .WARMUP_CYC   (WARM),
    .FILT_TIMEOUT (TOUT)
  ) dut (
    .lmmi_clk_i   (clk),
    .reset_n_i    (rst_n),
    .enable_i     (en),
    .conf_en_o    (conf_en_o),
    .adc_valid_i  (adc_valid),
    .adc_data_i   (adc_data),
    .filt_in_o    (filt_in_o),
    .filt_start_o (filt_start_o),
    .filt_done_i  (filt_done),
    .filt_out_i   (filt_out),
    .dac_data_o   (dac_data_o),
    .ch_o         (ch_o),
    .overrun_o    (overrun_o),
`ifdef AUDIO_SEQ_OVF_CNT_EN
    .ovf_cnt_o    (ovf_cnt_o),
`endif
    .timeout_o    (timeout_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_start = 0;
  int n_ovr   = 0;
  int n_to    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: "warmed" means codecs enabled, "busy" means a sample
  // is with the filter, age counts cycles the filter has been busy.
  bit          m_warming, m_warmed, m_busy;
  int          m_t, m_age, m_ovf;
  bit          m_start, m_ovr, m_to, m_ch;
  logic [DW-1:0] m_fin;
  logic [31:0] m_dac;

  task automatic model_step();
    int v;
    if (!rst_n) begin
      m_warming = 0; m_warmed = 0; m_busy = 0; m_t = 0; m_age = 0; m_ovf = 0;
      m_start = 0; m_ovr = 0; m_to = 0; m_ch = 0; m_fin = '0; m_dac = '0;
    end else begin
      m_start = 0; m_ovr = 0; m_to = 0;
      if (!en) begin
        m_warming = 0; m_warmed = 0; m_busy = 0; m_dac = '0; m_ch = 0; m_ovf = 0;
      end else if (!m_warmed) begin
        if (!m_warming) begin
          m_warming = 1; m_t = 0;
        end else begin
          m_t++;
          if (m_t == WARM) begin
            m_warmed = 1; m_warming = 0;
          end
        end
      end else if (!m_busy) begin
        if (adc_valid) begin
          v = int'(adc_data & 32'h00FF_FFFF);
          if (v >= (1 << 23)) v -= (1 << 24);
          v = v >>> SHIFT;
          m_fin = v[DW-1:0];
          m_start = 1; m_ch = !m_ch; m_busy = 1; m_age = 0;
        end
      end else begin
        m_age++;
        if (filt_done) begin
          v = int'(filt_out);
          if (v >= (1 << 23)) v -= (1 << 24);
          m_dac = v; m_busy = 0;
        end else if (m_age == TOUT) begin
          m_dac = 0; m_to = 1; m_busy = 0;
        end
        if (adc_valid) begin
          m_ovr = 1; m_ch = !m_ch;
        end
      end
      m_ovf = m_ovf + int'(m_ovr) + int'(m_to);
      if (m_ovf > 65535) m_ovf = 65535;
    end
  endtask

  // Every cycle: advance the model on the edge, then compare 1 time unit later.
  always @(posedge clk) begin
    model_step();
    #1;
    chk("conf_en",    32'(conf_en_o),    32'(m_warmed));
    chk("filt_in",    32'(filt_in_o),    32'(m_fin));
    chk("filt_start", 32'(filt_start_o), 32'(m_start));
    chk("dac_data",   dac_data_o,        m_dac);
    chk("ch",         32'(ch_o),         32'(m_ch));
    chk("overrun",    32'(overrun_o),    32'(m_ovr));
    chk("timeout",    32'(timeout_o),    32'(m_to));
`ifdef AUDIO_SEQ_OVF_CNT_EN
    chk("ovf_cnt",    32'(ovf_cnt_o),    32'(m_ovf));
`endif
    if (filt_start_o) begin
      n_start++;
      $display("txn sample ch=%0d filt_in=%h", ch_o, filt_in_o);
    end
    if (overrun_o) begin
      n_ovr++;
      $display("txn overrun ch=%0d", ch_o);
    end
    if (timeout_o) begin
      n_to++;
      $display("txn timeout dac=%h", dac_data_o);
    end
  end

  task automatic pulse_valid(input logic [31:0] d);
    adc_data  = d;
    adc_valid = 1'b1;
    @(negedge clk);
    adc_valid = 1'b0;
  endtask

  task automatic pulse_done(input logic [DW-1:0] r);
    filt_out  = r;
    filt_done = 1'b1;
    @(negedge clk);
    filt_done = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int k;
    int o0;
    int s0;
    int drate;

    // Reset state
    tick(3);
    chk("rst_conf", 32'(conf_en_o), 32'h0);
    chk("rst_dac", dac_data_o, 32'h0);
    chk("rst_ch", 32'(ch_o), 32'h0);
    chk("rst_start", 32'(filt_start_o), 32'h0);
    rst_n = 1'b1;
    tick(2);

    // Warm-up: conf_en exactly WARM edges after enable; samples ignored meanwhile
    en = 1'b1;
    adc_valid = 1'b1;
    adc_data = 32'h0000_1234;
    @(posedge clk);
    k = 0;
    while (conf_en_o !== 1'b1 && k < 200) begin
      @(posedge clk);
      k++;
      #2;
    end
    chk("warmup_cycles", 32'(k), 32'd64);
    chk("warmup_no_start", 32'(n_start), 32'd0);
    chk("warmup_ch", 32'(ch_o), 32'h0);
    @(negedge clk);
    adc_valid = 1'b0;

    // Shift and sign extension
    pulse_valid(32'h0080_0000);
    chk("shift_filt_in", 32'(filt_in_o), 32'h00F0_0000);
    chk("shift_start", 32'(filt_start_o), 32'h1);
    chk("shift_ch", 32'(ch_o), 32'h1);
    tick(3);
    pulse_done(24'hFFFFFE);
    chk("sext_dac", dac_data_o, 32'hFFFF_FFFE);

    // Done and sample in the same cycle
    pulse_valid(32'h0000_0100);
    tick(2);
    filt_out = 24'h123456; filt_done = 1'b1;
    adc_valid = 1'b1; adc_data = 32'h0000_0200;
    @(negedge clk);
    filt_done = 1'b0; adc_valid = 1'b0;
    chk("same_dac", dac_data_o, 32'h0012_3456);
    chk("same_overrun", 32'(overrun_o), 32'h1);
    pulse_valid(32'h0000_0300);
    chk("same_next_start", 32'(filt_start_o), 32'h1);
    chk("same_next_ch", 32'(ch_o), 32'h0);
    tick(1);
    pulse_done(24'h000010);

    // Overrun ten cycles into a filter run
    o0 = n_ovr;
    pulse_valid(32'h0000_0400);
    tick(9);
    pulse_valid(32'h0000_0500);
    tick(2);
    chk("ovr_count", 32'(n_ovr - o0), 32'd1);
    chk("ovr_ch", 32'(ch_o), 32'h0);
    pulse_done(24'h000042);
    chk("ovr_late_done", dac_data_o, 32'h0000_0042);

    // Filter timeout
    pulse_valid(32'h0000_0600);
    k = 0;
    while (timeout_o !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("tout_cycles", 32'(k), 32'd255);
    chk("tout_dac", dac_data_o, 32'h0);
    s0 = n_start;
    pulse_valid(32'h0000_0700);
    chk("tout_restart", 32'(n_start - s0), 32'd1);
    tick(1);
    pulse_done(24'h000321);

    // Enable dropped while running
    pulse_valid(32'h0000_0800);
    tick(1);
    en = 1'b0;
    @(negedge clk);
    chk("dis_conf", 32'(conf_en_o), 32'h0);
    chk("dis_dac", dac_data_o, 32'h0);
    chk("dis_ch", 32'(ch_o), 32'h0);
`ifdef AUDIO_SEQ_OVF_CNT_EN
    chk("dis_ovf", 32'(ovf_cnt_o), 32'h0);
`endif

    // Asynchronous reset pulse mid-run, result in flight discarded
    en = 1'b1;
    k = 0;
    while (conf_en_o !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("reen_conf", 32'(conf_en_o), 32'h1);
    pulse_valid(32'h0000_0900);
    tick(2);
    pulse_done(24'h000777);
    pulse_valid(32'h0000_0A00);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_conf", 32'(conf_en_o), 32'h0);
    chk("arst_dac", dac_data_o, 32'h0);
    chk("arst_ch", 32'(ch_o), 32'h0);
`ifdef AUDIO_SEQ_OVF_CNT_EN
    chk("arst_ovf", 32'(ovf_cnt_o), 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    pulse_done(24'h7FFFFF);
    chk("arst_done_ignored", dac_data_o, 32'h0);

    // Random traffic; every fourth segment starves the filter
    for (int seg = 0; seg < 8; seg++) begin
      drate = (seg % 4 == 3) ? 0 : int'($urandom_range(3, 25));
      for (int c = 0; c < 500; c++) begin
        @(negedge clk);
        adc_valid = ($urandom_range(0, 24) == 0);
        adc_data  = $urandom;
        filt_done = (drate != 0) && ($urandom_range(0, drate - 1) == 0);
        filt_out  = DW'($urandom);
        en        = ($urandom_range(0, 799) != 0);
        if (seg == 5 && c == 100) rst_n = 1'b0;
        if (seg == 5 && c == 101) rst_n = 1'b1;
      end
    end
    @(negedge clk);
    adc_valid = 1'b0; filt_done = 1'b0; en = 1'b1;
    tick(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
